// File: rtl/dmem_bridge.sv
// Load/store bridge: sequences 1/2/4 big-endian byte beats to a byte-wide data
// memory, checks alignment and sign/zero-extends assembled load data.
module dmem_bridge #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  input  logic              we,
  input  logic [1:0]        size,
  input  logic              uns,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic              ready,
  output logic              done,
  output logic              err,
  output logic [31:0]       rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [7:0]        mem_rdata
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_RTAIL  = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [1:0]        beat_q, beat_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic [1:0]        size_q, size_d;
  logic              uns_q, uns_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              err_q, err_d;
  logic [31:0]       acc_q, acc_d;
  logic              rvld_q, rvld_d;
  logic [31:0]       rdata_q, rdata_d;

  logic [1:0]  last_beat;
  logic [1:0]  byte_idx;
  logic [31:0] wshift;
  logic        misal;
  logic        in_access;

  always_comb begin
    case (size_q)
      2'b00:   last_beat = 2'd0;
      2'b01:   last_beat = 2'd1;
      default: last_beat = 2'd3;
    endcase
  end

  // Most significant byte of the right-aligned store data goes out first.
  assign byte_idx = last_beat - beat_q;
  assign wshift   = wdata_q >> {byte_idx, 3'b000};
  assign misal    = (size == 2'b11) || (size == 2'b01 && addr[0]) ||
                    (size == 2'b10 && addr[1:0] != 2'b00);

  assign in_access = (state_q == S_ACCESS);
  assign ready     = (state_q == S_IDLE);
  assign done      = (state_q == S_DONE);
  assign err       = done & err_q;
  assign mem_we    = in_access & we_q;
  assign mem_re    = in_access & ~we_q;
  assign mem_addr  = in_access ? addr_q + {{(ADDR_W-2){1'b0}}, beat_q} : '0;
  assign mem_wdata = mem_we ? wshift[7:0] : 8'h00;
  assign rdata     = rdata_q;

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    addr_d  = addr_q;
    we_d    = we_q;
    size_d  = size_q;
    uns_d   = uns_q;
    wdata_d = wdata_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    rvld_d  = mem_re;
    // Read data trails mem_re by one cycle, so shift in whenever last cycle read.
    acc_d   = rvld_q ? {acc_q[23:0], mem_rdata} : acc_q;
    case (state_q)
      S_IDLE: begin
        err_d = 1'b0;
        if (req) begin
          addr_d  = addr;
          we_d    = we;
          size_d  = size;
          uns_d   = uns;
          wdata_d = wdata;
          err_d   = misal;
          beat_d  = 2'd0;
          acc_d   = 32'h0;
          state_d = misal ? S_DONE : S_ACCESS;
        end
      end
      S_ACCESS: begin
        if (beat_q == last_beat) state_d = we_q ? S_DONE : S_RTAIL;
        else                     beat_d  = beat_q + 2'd1;
      end
      S_RTAIL: begin
        state_d = S_DONE;
        case (size_q)
          2'b00:   rdata_d = uns_q ? {24'h0, acc_d[7:0]}  : {{24{acc_d[7]}}, acc_d[7:0]};
          2'b01:   rdata_d = uns_q ? {16'h0, acc_d[15:0]} : {{16{acc_d[15]}}, acc_d[15:0]};
          default: rdata_d = acc_d;
        endcase
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      beat_q  <= 2'd0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      size_q  <= 2'b00;
      uns_q   <= 1'b0;
      wdata_q <= 32'h0;
      err_q   <= 1'b0;
      acc_q   <= 32'h0;
      rvld_q  <= 1'b0;
      rdata_q <= 32'h0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
      acc_q   <= acc_d;
      rvld_q  <= rvld_d;
      rdata_q <= rdata_d;
    end
  end

endmodule

// File: tb/tb_dmem_bridge.sv
// Directed bench for dmem_bridge with a synchronous byte-memory model.
module tb_dmem_bridge;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req = 1'b0, we = 1'b0, uns = 1'b0;
  logic [1:0]  size = 2'b00;
  logic [31:0] addr = 32'h0, wdata = 32'h0;
  logic        ready, done, err;
  logic [31:0] rdata, mem_addr;
  logic [7:0]  mem_wdata, mem_rdata;
  logic        mem_we, mem_re;

  logic [7:0]  mem [0:255];
  logic        preload = 1'b1;
  logic [7:0]  rd_q = 8'h00;

  int n_cmp = 0, n_bad = 0;
  logic [31:0] wa [0:7];
  logic [7:0]  wd [0:7];

  dmem_bridge #(.ADDR_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .we(we), .size(size), .uns(uns),
    .addr(addr), .wdata(wdata), .ready(ready), .done(done), .err(err),
    .rdata(rdata), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_we(mem_we), .mem_re(mem_re), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  assign mem_rdata = rd_q;
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
      mem[8'h20] <= 8'h84;
      mem[8'h32] <= 8'h5A;
      mem[8'h33] <= 8'hA5;
    end else begin
      if (mem_we) mem[mem_addr[7:0]] <= mem_wdata;
      if (mem_re) rd_q <= mem[mem_addr[7:0]];
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Issue one request; cycle 0 is the accept edge, counts run until done.
  task automatic do_req(input logic w, input logic [1:0] sz, input logic u,
                        input logic [31:0] a, input logic [31:0] d,
                        output int dcyc, output logic e, output int nwe, output int nre);
    dcyc = 0; e = 1'b0; nwe = 0; nre = 0;
    @(negedge clk);
    req = 1'b1; we = w; size = sz; uns = u; addr = a; wdata = d;
    @(posedge clk);
    #1 req = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (mem_we) begin wa[nwe[2:0]] = mem_addr; wd[nwe[2:0]] = mem_wdata; nwe++; end
      if (mem_re) nre++;
      if (done) begin dcyc = c; e = err; break; end
    end
    if (dcyc == 0) chk("done_timeout", 32'd0, 32'd1);
  endtask

  int dc, nw, nr;
  logic e;
  logic [31:0] r_prev;
  int pulses;

  initial begin
    #3;
    chk("rst_ready", {31'd0, ready}, 32'd1);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_mem", {mem_addr[7:0], mem_wdata, 6'd0, mem_we, mem_re}, 32'h0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1; preload = 1'b0;

    do_req(1'b1, 2'b10, 1'b0, 32'h10, 32'h11223344, dc, e, nw, nr);
    chk("sw_done_cyc", dc, 5);
    chk("sw_err", {31'd0, e}, 0);
    chk("sw_nwe", nw, 4);
    chk("sw_nre", nr, 0);
    chk("sw_addr", {wa[0][7:0], wa[1][7:0], wa[2][7:0], wa[3][7:0]}, 32'h10111213);
    chk("sw_data", {wd[0], wd[1], wd[2], wd[3]}, 32'h11223344);
    chk("sw_rdata_kept", rdata, 32'h0);

    do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, dc, e, nw, nr);
    chk("lw_done_cyc", dc, 6);
    chk("lw_nre", nr, 4);
    chk("lw_nwe", nw, 0);
    chk("lw_rdata", rdata, 32'h11223344);

    do_req(1'b0, 2'b00, 1'b0, 32'h20, 32'h0, dc, e, nw, nr);
    chk("lb_done_cyc", dc, 3);
    chk("lb_rdata", rdata, 32'hFFFFFF84);
    do_req(1'b0, 2'b00, 1'b1, 32'h20, 32'h0, dc, e, nw, nr);
    chk("lbu_rdata", rdata, 32'h00000084);

    do_req(1'b1, 2'b01, 1'b0, 32'h22, 32'h0000BEEF, dc, e, nw, nr);
    chk("sh_done_cyc", dc, 3);
    chk("sh_data", {16'h0, wd[0], wd[1]}, 32'h0000BEEF);
    chk("sh_rdata_kept", rdata, 32'h00000084);
    do_req(1'b0, 2'b01, 1'b0, 32'h22, 32'h0, dc, e, nw, nr);
    chk("lh_done_cyc", dc, 4);
    chk("lh_rdata", rdata, 32'hFFFFBEEF);
    do_req(1'b0, 2'b01, 1'b1, 32'h22, 32'h0, dc, e, nw, nr);
    chk("lhu_rdata", rdata, 32'h0000BEEF);

    r_prev = rdata;
    do_req(1'b0, 2'b01, 1'b0, 32'h11, 32'h0, dc, e, nw, nr);
    chk("mis_lh_cyc", dc, 1);
    chk("mis_lh_err", {31'd0, e}, 1);
    chk("mis_lh_mem", nw + nr, 0);
    chk("mis_lh_rdata", rdata, r_prev);
    do_req(1'b1, 2'b10, 1'b0, 32'h12, 32'hDEADBEEF, dc, e, nw, nr);
    chk("mis_sw_cyc", dc, 1);
    chk("mis_sw_err", {31'd0, e}, 1);
    chk("mis_sw_mem", nw + nr, 0);
    chk("mis_sw_mem13", {24'h0, mem[8'h13]}, 32'h44);
    do_req(1'b0, 2'b11, 1'b0, 32'h10, 32'h0, dc, e, nw, nr);
    chk("ill_cyc", dc, 1);
    chk("ill_err", {31'd0, e}, 1);
    chk("ill_mem", nw + nr, 0);
    chk("ill_rdata", rdata, r_prev);
    @(negedge clk);
    chk("err_clear", {31'd0, err}, 0);

    // Word store interrupted by reset while its third beat is on the bus.
    @(negedge clk);
    req = 1'b1; we = 1'b1; size = 2'b10; uns = 1'b0; addr = 32'h30; wdata = 32'hAABBCCDD;
    @(posedge clk);
    #1 req = 1'b0;
    pulses = 0;
    repeat (3) begin
      @(negedge clk);
      if (done) pulses++;
    end
    chk("mid_beat2_addr", mem_addr, 32'h32);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_ready", {31'd0, ready}, 1);
    chk("mid_rst_mem", {mem_addr[7:0], mem_wdata, 6'd0, mem_we, mem_re}, 32'h0);
    chk("mid_rst_rdata", rdata, 32'h0);
    chk("mid_rst_done", {31'd0, done}, 0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    do_req(1'b0, 2'b00, 1'b0, 32'h30, 32'h0, dc, e, nw, nr);
    chk("post_rst_done_cyc", dc, 3);
    chk("post_rst_rdata", rdata, 32'hFFFFFFAA);
    chk("mid_pulses", pulses, 0);
    chk("mid_mem", {mem[8'h30], mem[8'h31], mem[8'h32], mem[8'h33]}, 32'hAABB5AA5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
